// File: rtl/flags_reader_pkg.sv
// Shared bit positions and encodings for the flag-read block:
// compressed status layout, architectural EFLAGS layout, FSM states.
package flags_reader_pkg;

  localparam int STAT_W  = 7;
  localparam int STAT_OF = 0;
  localparam int STAT_SF = 1;
  localparam int STAT_ZF = 2;
  localparam int STAT_PF = 3;
  localparam int STAT_CF = 4;
  localparam int STAT_AF = 5;
  localparam int STAT_DF = 6;

  localparam int EFLAGS_W    = 32;
  localparam int EFLAGS_CF   = 0;
  localparam int EFLAGS_RSV1 = 1;
  localparam int EFLAGS_PF   = 2;
  localparam int EFLAGS_AF   = 4;
  localparam int EFLAGS_ZF   = 6;
  localparam int EFLAGS_SF   = 7;
  localparam int EFLAGS_TF   = 8;
  localparam int EFLAGS_IF   = 9;
  localparam int EFLAGS_DF   = 10;
  localparam int EFLAGS_OF   = 11;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  typedef enum logic {
    REQ_LAHF  = 1'b0,
    REQ_PUSHF = 1'b1
  } req_kind_e;

endpackage

// File: rtl/status_to_eflags.sv
// Expands the 7-bit compressed status into an architectural EFLAGS word.
// TF and IF are not tracked here and always read as zero.
module status_to_eflags
  import flags_reader_pkg::*;
(
  input  logic [STAT_W-1:0]   status_i,
  output logic [EFLAGS_W-1:0] eflags_o
);

  always_comb begin
    eflags_o              = '0;
    eflags_o[EFLAGS_CF]   = status_i[STAT_CF];
    eflags_o[EFLAGS_RSV1] = 1'b1;
    eflags_o[EFLAGS_PF]   = status_i[STAT_PF];
    eflags_o[EFLAGS_AF]   = status_i[STAT_AF];
    eflags_o[EFLAGS_ZF]   = status_i[STAT_ZF];
    eflags_o[EFLAGS_SF]   = status_i[STAT_SF];
    eflags_o[EFLAGS_TF]   = 1'b0;
    eflags_o[EFLAGS_IF]   = 1'b0;
    eflags_o[EFLAGS_DF]   = status_i[STAT_DF];
    eflags_o[EFLAGS_OF]   = status_i[STAT_OF];
  end

endmodule

// File: rtl/flags_reader.sv
// Holds the compressed status register and answers LAHF/PUSHF reads
// through a one-entry response buffer with same-cycle update forwarding.
module flags_reader
  import flags_reader_pkg::*;
#(
  parameter logic [STAT_W-1:0] RESET_STATUS = 7'h00
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                upd_valid,
  input  logic [STAT_W-1:0]   upd_status,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_kind,
  input  logic [31:0]         req_eax,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_data,
  output logic                rsp_ah_wr,
  output logic [STAT_W-1:0]   status
);

  rsp_state_e          state_q, state_d;
  logic [STAT_W-1:0]   status_q, status_d;
  logic [31:0]         rsp_data_q, rsp_data_d;
  logic                rsp_ah_wr_q, rsp_ah_wr_d;

  logic                req_fire;
  logic [STAT_W-1:0]   src_status;
  logic [EFLAGS_W-1:0] src_eflags;

  assign req_ready  = (state_q == RSP_EMPTY) || rsp_ready;
  assign req_fire   = req_valid && req_ready;
  // An update landing in the acceptance cycle is the newest status.
  assign src_status = upd_valid ? upd_status : status_q;

  status_to_eflags u_pack (
    .status_i (src_status),
    .eflags_o (src_eflags)
  );

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    rsp_data_d  = rsp_data_q;
    rsp_ah_wr_d = rsp_ah_wr_q;
    if (upd_valid) status_d = upd_status;
    if (req_fire) begin
      state_d = RSP_FULL;
      if (req_kind == REQ_PUSHF) begin
        rsp_data_d  = src_eflags;
        rsp_ah_wr_d = 1'b0;
      end else begin
        rsp_data_d  = {req_eax[31:16], src_eflags[7:0], req_eax[7:0]};
        rsp_ah_wr_d = 1'b1;
      end
    end else if (rsp_ready) begin
      state_d = RSP_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RSP_EMPTY;
      status_q    <= RESET_STATUS;
      rsp_data_q  <= '0;
      rsp_ah_wr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ah_wr_q <= rsp_ah_wr_d;
    end
  end

  assign rsp_valid = (state_q == RSP_FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_ah_wr = rsp_ah_wr_q;
  assign status    = status_q;

endmodule
